// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow asynchronous input in clkIn cycles.
// Rising edges delimit periods; no rising edge for TIMEOUT cycles raises a sticky timeout flag.
module clk_period_meter #(
  parameter int CNT_W       = 26,
  parameter int TIMEOUT     = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkIn,
  input  logic             rstN,
  input  logic             sigIn,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] highTime,
  output logic             periodValid,
  output logic             timeout,
  output logic             measuring
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meterStateT;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  // Synchronizer chain and edge flop
  logic [SYNC_STAGES-1:0] syncReg;
  logic                   sPrevReg;
  logic                   sSync;
  logic                   rise;
  logic                   fall;

  // Measurement state
  meterStateT       stateReg,    stateNext;
  logic [CNT_W-1:0] counterReg,  counterNext;
  logic [CNT_W-1:0] counterInc;
  logic [CNT_W-1:0] hiLatchReg,  hiLatchNext;
  logic             fallSeenReg, fallSeenNext;
  logic [CNT_W-1:0] periodReg,   periodNext;
  logic [CNT_W-1:0] highTimeReg, highTimeNext;
  logic             validReg,    validNext;
  logic             timeoutReg,  timeoutNext;

  assign sSync = syncReg[SYNC_STAGES-1];
  assign rise  = sSync & ~sPrevReg;
  assign fall  = ~sSync & sPrevReg;

  // Counter sticks at all-ones rather than wrapping to a misleading small value
  assign counterInc = (counterReg == CNT_MAX) ? counterReg : counterReg + 1'b1;

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      syncReg     <= '0;
      sPrevReg    <= 1'b0;
      stateReg    <= IDLE;
      counterReg  <= '0;
      hiLatchReg  <= '0;
      fallSeenReg <= 1'b0;
      periodReg   <= '0;
      highTimeReg <= '0;
      validReg    <= 1'b0;
      timeoutReg  <= 1'b0;
    end else begin
      syncReg     <= {syncReg[SYNC_STAGES-2:0], sigIn};
      sPrevReg    <= sSync;
      stateReg    <= stateNext;
      counterReg  <= counterNext;
      hiLatchReg  <= hiLatchNext;
      fallSeenReg <= fallSeenNext;
      periodReg   <= periodNext;
      highTimeReg <= highTimeNext;
      validReg    <= validNext;
      timeoutReg  <= timeoutNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    counterNext  = counterReg;
    hiLatchNext  = hiLatchReg;
    fallSeenNext = fallSeenReg;
    periodNext   = periodReg;
    highTimeNext = highTimeReg;
    validNext    = 1'b0;
    timeoutNext  = timeoutReg;

    unique case (stateReg)
      IDLE: begin
        counterNext = '0;
        if (rise) begin
          counterNext  = CNT_W'(1);
          hiLatchNext  = '0;
          fallSeenNext = 1'b0;
          timeoutNext  = 1'b0;
          stateNext    = MEASURE;
        end
      end

      MEASURE: begin
        counterNext = counterInc;
        if (fall) begin
          hiLatchNext  = counterReg;
          fallSeenNext = 1'b1;
        end
        // A rise on the last allowed cycle still counts as a valid period
        if (rise) begin
          periodNext   = counterReg;
          highTimeNext = fallSeenReg ? hiLatchReg : counterReg;
          validNext    = 1'b1;
          counterNext  = CNT_W'(1);
          fallSeenNext = 1'b0;
        end else if (counterReg == TIMEOUT_LAST) begin
          timeoutNext  = 1'b1;
          periodNext   = '0;
          highTimeNext = '0;
          counterNext  = '0;
          stateNext    = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign period      = periodReg;
  assign highTime    = highTimeReg;
  assign periodValid = validReg;
  assign timeout     = timeoutReg;
  assign measuring   = (stateReg == MEASURE);

endmodule
